// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used to decide whether an access may touch memory.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // A dword access only exists on a 64-bit datapath.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [2:0] low,
                                           input logic       is_xlen64);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = low[0];
            SZ_W:    mis = (low[1:0] != 2'b00);
            default: mis = !is_xlen64 || (low != 3'b000);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load return path: shift the addressed bytes down to bit 0 and extend
// them to the full register width.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OW   = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] data,
    input  logic [OW-1:0]   offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] ext
);

    logic [XLEN-1:0] sh;

    // Lane shift, then truncate to the access size and zero/sign extend.
    always_comb begin
        sh  = data >> {offset, 3'b000};
        ext = sh;
        case (size)
            SZ_B: begin
                if (is_unsigned) ext = XLEN'(sh[7:0]);
                else             ext = XLEN'($signed(sh[7:0]));
            end
            SZ_H: begin
                if (is_unsigned) ext = XLEN'(sh[15:0]);
                else             ext = XLEN'($signed(sh[15:0]));
            end
            SZ_W: begin
                if (is_unsigned) ext = XLEN'(sh[31:0]);
                else             ext = XLEN'($signed(sh[31:0]));
            end
            default: ext = sh;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between the core and a word-wide
// memory port, with misalignment trapping and a response timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a core request
// REQ     | mem_valid held, waiting for mem_ready
// WAIT    | load accepted by memory, waiting for mem_rvalid
// RESP    | one-cycle resp_valid pulse, result registers updated
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [OW-1:0]   off_q;
    logic [XLEN-1:0] load_ext;
    logic [NB-1:0]   wmask_d;
    logic            misaligned;
    logic            timeout;

    assign misaligned = is_misaligned(req_size, req_addr[2:0], XLEN == 64);
    // >= rather than ==: a load accepted on the last REQ cycle still gets
    // one WAIT cycle before it times out.
    assign timeout    = (cnt_q >= CW'(TIMEOUT - 1));

    // Byte-lane enables for the incoming store, from size and offset.
    always_comb begin
        wmask_d = '0;
        for (int b = 0; b < NB; b++) begin
            if ((b >= int'(req_addr[OW-1:0])) &&
                (b < int'(req_addr[OW-1:0]) + (1 << req_size)))
                wmask_d[b] = 1'b1;
        end
    end

    lsu_align #(.XLEN(XLEN), .OW(OW)) u_align (
        .data        (mem_rdata),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ext         (load_ext)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and handshake outputs; completion beats timeout.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = misaligned ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                mem_valid = 1'b1;
                if (mem_ready)    state_d = mem_we ? ST_RESP : ST_WAIT;
                else if (timeout) state_d = ST_RESP;
            end
            ST_WAIT: begin
                if (mem_rvalid || timeout) state_d = ST_RESP;
            end
            default: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Request capture, memory bus registers, cycle counter and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            off_q      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (req_valid) begin
                        size_q <= req_size;
                        uns_q  <= req_unsigned;
                        off_q  <= req_addr[OW-1:0];
                        if (misaligned) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[AW-1:OW], {OW{1'b0}}};
                            mem_wdata <= req_we ? (req_wdata << {req_addr[OW-1:0], 3'b000}) : '0;
                            mem_wmask <= req_we ? wmask_d : '0;
                        end
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_ready) begin
                        if (mem_we) begin
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end
                    end else if (timeout) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_rvalid) begin
                        resp_err   <= 1'b0;
                        resp_rdata <= load_ext;
                    end else if (timeout) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed corner cases plus randomized accesses against a
// cycle-level reference of the access timing and data rules.
module tb_lsu;

    localparam int XLEN = 32;
    localparam int AW   = 32;
    localparam int TO   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]        req_size;
    logic [AW-1:0]     req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid, resp_err;
    logic [XLEN-1:0]   resp_rdata;
    logic              mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [AW-1:0]     mem_addr;
    logic [XLEN-1:0]   mem_wdata, mem_rdata;
    logic [XLEN/8-1:0] mem_wmask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu #(.XLEN(XLEN), .AW(AW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Load result from plain arithmetic: pick bytes, then sign-extend by
    // subtracting the size range when the top bit of the value is set.
    function automatic logic [31:0] load_model(input logic [31:0] rd, input int off,
                                               input int nb, input bit uns);
        longint unsigned v;
        longint unsigned lim;
        v = longint'(rd) >> (8 * off);
        if (nb < 4) begin
            lim = 64'd1 << (8 * nb);
            v   = v % lim;
            if (!uns && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
        end
        return v[31:0];
    endfunction

    // One access: rlat = cycles of mem_ready low in REQ, vlat = cycles of
    // rvalid low in WAIT (negative = never). Checks every cycle until the
    // response and the idle cycle after it.
    task automatic access(input string nm, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int rlat, input int vlat, input logic [31:0] rdv);
        int off, nb, c_h, c_v, lim, resp_c, req_end, wait_end;
        bit mis, exp_err;
        logic [31:0] exp_rd, exp_addr, exp_wdata;
        logic [3:0]  exp_mask;
        off = int'(addr % 4);
        nb  = 1 << size;
        mis = (size == 2'd3) || (addr % nb != 0);
        c_h = 0; c_v = -1; wait_end = 0; exp_rd = '0; exp_err = 1'b1;
        if (mis) begin
            req_end = 0; resp_c = 1;
        end else if (rlat >= TO) begin
            req_end = TO; resp_c = TO + 1;
        end else begin
            c_h = 1 + rlat; req_end = c_h;
            if (we) begin
                resp_c = c_h + 1; exp_err = 1'b0;
            end else begin
                lim = (c_h + 1 > TO) ? c_h + 1 : TO;
                if (vlat >= 0) c_v = c_h + 1 + vlat;
                if (vlat < 0 || c_v > lim) begin
                    resp_c = lim + 1; c_v = -1;
                end else begin
                    resp_c = c_v + 1; exp_err = 1'b0;
                    exp_rd = load_model(rdv, off, nb, uns);
                end
                wait_end = resp_c - 1;
            end
        end
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_mask  = we ? 4'(((1 << nb) - 1) << off) : 4'h0;
        exp_wdata = wdata << (8 * off);

        @(negedge clk);
        check({nm, "_ready_idle"}, req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; mem_ready = 1'b0; mem_rvalid = 1'b0;
        for (int c = 1; c <= resp_c + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
                req_we = 1'($urandom); req_size = 2'($urandom);
            end
            if (c <= resp_c) begin
                check({nm, "_ready_busy"}, req_ready, 0);
                check({nm, "_resp_valid"}, resp_valid, (c == resp_c));
                check({nm, "_mem_valid"}, mem_valid, (c <= req_end));
                if (c <= req_end) begin
                    check({nm, "_mem_addr"}, mem_addr, exp_addr);
                    check({nm, "_mem_we"}, mem_we, we);
                    check({nm, "_mem_wmask"}, mem_wmask, exp_mask);
                    if (we) check({nm, "_mem_wdata"}, mem_wdata, exp_wdata);
                end
                if (c == resp_c) begin
                    check({nm, "_resp_err"}, resp_err, exp_err);
                    check({nm, "_resp_rdata"}, resp_rdata, exp_rd);
                end
                mem_ready  = (c <= req_end) ? (c == c_h) : 1'($urandom);
                mem_rvalid = (c > c_h && c <= wait_end) ? (c == c_v) : 1'($urandom);
                mem_rdata  = (c == c_v) ? rdv : $urandom;
            end else begin
                check({nm, "_resp_drop"}, resp_valid, 0);
                check({nm, "_ready_back"}, req_ready, 1);
                check({nm, "_err_hold"}, resp_err, exp_err);
                check({nm, "_rdata_hold"}, resp_rdata, exp_rd);
                mem_ready = 1'b0; mem_rvalid = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] a, w, d;
        logic [1:0]  sz;
        int          rl, vl;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        access("sb_byte3",   1, 2'd0, 0, 32'h8000_0003, 32'h0000_00AB, 0, 0, 32'h0);
        access("lb_signed",  0, 2'd0, 0, 32'h1000_0002, 32'h0, 0, 0, 32'h0080_0000);
        access("lbu",        0, 2'd0, 1, 32'h1000_0002, 32'h0, 0, 0, 32'h0080_0000);
        access("lw_misal",   0, 2'd2, 0, 32'h1000_0001, 32'h0, 0, 0, 32'h0);
        access("sh_bp5",     1, 2'd1, 0, 32'h2000_0006, 32'h0000_BEEF, 5, 0, 32'h0);
        access("lh_bp5",     0, 2'd1, 0, 32'h2000_0002, 32'h0, 5, 2, 32'h8123_4567);
        access("lw_tmo",     0, 2'd2, 0, 32'h3000_0004, 32'h0, 0, -1, 32'h0);
        access("sw_tmo",     1, 2'd2, 0, 32'h3000_0008, 32'h1234_5678, TO, 0, 32'h0);
        access("lw_lastok",  0, 2'd2, 0, 32'h3000_000C, 32'h0, 0, TO - 2, 32'hCAFE_F00D);
        access("lw_late",    0, 2'd2, 0, 32'h3000_000C, 32'h0, 0, TO - 1, 32'hCAFE_F00D);
        access("sw_lastrdy", 1, 2'd2, 0, 32'h3000_0010, 32'hA5A5_5A5A, TO - 1, 0, 32'h0);
        access("lhu_lastrdy",0, 2'd1, 1, 32'h3000_0012, 32'h0, TO - 1, 0, 32'hFEDC_BA98);
        access("lw_rdy7_v1", 0, 2'd2, 0, 32'h3000_0014, 32'h0, TO - 1, 1, 32'h1111_2222);
        access("dw_on32",    0, 2'd3, 0, 32'h3000_0018, 32'h0, 0, 0, 32'h0);

        // Reset while a load sits in WAIT, then a stray rvalid afterwards.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h4000_0010;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        check("wait_mem_valid", mem_valid, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_resp_valid", resp_valid, 0);
        check("arst_mem_valid", mem_valid, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_mem_wmask", mem_wmask, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_resp_err", resp_err, 0);
        check("arst_resp_rdata", resp_rdata, 0);
        check("arst_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_resp_valid", resp_valid, 0);
            check("stray_ready", req_ready, 1);
            check("stray_mem_valid", mem_valid, 0);
        end
        mem_rvalid = 1'b0; mem_ready = 1'b0;
        access("post_rst_lw", 0, 2'd2, 0, 32'h4000_0020, 32'h0, 1, 1, 32'h7654_3210);

        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(3, 0) != 0) a = a & ~((32'd1 << sz) - 1);
            w  = $urandom;
            d  = $urandom;
            rl = ($urandom_range(7, 0) == 0) ? TO + int'($urandom_range(1, 0)) : int'($urandom_range(3, 0));
            vl = ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(3, 0));
            access("rand", 1'($urandom), sz, 1'($urandom), a, w, rl, vl, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data width in bits (32 or 64); AW, default 32, byte-address width; TIMEOUT, default 255, max cycles awaiting memory before error.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  req_valid  in  1  core access request
  req_ready  out  1  lsu can accept request
  req_we  in  1  1 = store, 0 = load
  req_size  in  2  0 byte, 1 half, 2 word, 3 dword (XLEN=64 only)
  req_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
  req_addr  in  AW  byte address
  req_wdata  in  XLEN  store data, right-aligned
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  XLEN  aligned, extended load data
  resp_err  out  1  misaligned or timeout
  mem_valid  out  1  memory request valid
  mem_ready  in  1  memory accepts request
  mem_we  out  1  memory write
  mem_addr  out  AW  XLEN/8-aligned address
  mem_wdata  out  XLEN  lane-shifted store data
  mem_wmask  out  XLEN/8  byte-lane enables
  mem_rvalid  in  1  read data valid
  mem_rdata  in  XLEN  full-word read data

Function
REQ-003 FSM SHALL have states IDLE, REQ, WAIT, RESP; one outstanding access only.
REQ-004 req_ready SHALL be 1 only in IDLE; handshake = req_valid && req_ready; all request fields registered at handshake.
REQ-005 Misaligned (half with addr[0]=1; word with addr[1:0]!=0; dword with addr[2:0]!=0; size 3 when XLEN=32) SHALL skip memory, go IDLE->RESP, resp_err=1, resp_rdata=0.
REQ-006 Aligned request SHALL go IDLE->REQ; mem_valid=1 held with stable mem_* until mem_ready sampled 1.
REQ-007 mem_addr SHALL be req_addr with low log2(XLEN/8) bits cleared.
REQ-008 Store: mem_wdata = req_wdata << (8*offset); mem_wmask = ((1<<(1<<size))-1) << offset; REQ->RESP on handshake, resp_err=0.
REQ-009 Load: mem_wmask=0, REQ->WAIT on handshake; WAIT->RESP on mem_rvalid; mem_rdata captured same edge.
REQ-010 Load result SHALL be mem_rdata >> (8*offset), truncated to access size, sign-extended unless req_unsigned; req_unsigned ignored for full-XLEN loads.
REQ-011 Cycle counter SHALL clear on entry to REQ, increment each cycle in REQ/WAIT; on reaching TIMEOUT without completing handshake SHALL go RESP with resp_err=1, resp_rdata=0, mem_valid deasserted.
REQ-012 mem_rvalid outside WAIT and mem_ready outside REQ SHALL be ignored.
REQ-013 RESP SHALL last exactly one cycle (resp_valid=1), then IDLE; resp_rdata/resp_err SHALL hold until next RESP.
REQ-014 Minimum latency: store with mem_ready=1 -> resp_valid 2 cycles after request handshake; load with same-cycle-next rvalid -> 3 cycles.

Reset
REQ-015 rst SHALL asynchronously force IDLE, counter 0, resp_valid=0, resp_err=0, resp_rdata=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0; req_ready=1 after release.
REQ-016 Reset mid-access SHALL abandon it with no resp_valid pulse; late mem_rvalid after release SHALL be ignored.

Structure
REQ-017 Shared package SHALL hold the size encoding (SZ_B/SZ_H/SZ_W/SZ_D) and FSM state enum.
REQ-018 Load align/extend SHALL be a combinational sub-module lsu_align (inputs data, offset, size, unsigned; output extended value).

Verification
REQ-019 Store byte: addr 0x8000_0003, size 0, wdata 0xAB, mem_ready=1 -> mem_addr 0x8000_0000, wmask 4'b1000, wdata 0xAB00_0000, resp_valid 2 cycles later, err 0.
REQ-020 Load lb vs lbu: addr 0x...02, mem_rdata 0x0080_0000 -> lb 0xFFFF_FF80, lbu 0x0000_0080.
REQ-021 Misaligned lw at 0x...01 -> no mem_valid, resp_valid next cycle, err 1, rdata 0.
REQ-022 Backpressure: mem_ready low 5 cycles -> mem_* stable, single resp after handshake.
REQ-023 Timeout: TIMEOUT=8, mem_rvalid never -> resp_err=1 exactly at timeout, FSM back to IDLE.
REQ-024 rst asserted in WAIT -> outputs zero immediately, no resp_valid, stray mem_rvalid ignored.
